// File: rtl/ysyx_22050019_axi_lsu_master.sv
// AXI-lite initiator for the LSU: one load (AR->R) or one store (AW+W->B) at a time.
// Optional YSYX_22050019_LSU_MISALIGN_CHECK_EN rejects misaligned requests with SLVERR and no bus traffic.
module ysyx_22050019_axi_lsu_master #(
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned AXI_ADDR_WIDTH = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_we,
    input  logic [AXI_ADDR_WIDTH-1:0]     req_addr,
    input  logic [1:0]                    req_size,
    input  logic [AXI_DATA_WIDTH-1:0]     req_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0]   req_wstrb,
    output logic                          rsp_valid,
    output logic [AXI_DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                    rsp_resp,
    output logic                          axi_aw_valid_o,
    input  logic                          axi_aw_ready_i,
    output logic [AXI_ADDR_WIDTH-1:0]     axi_aw_addr_o,
    output logic                          axi_w_valid_o,
    input  logic                          axi_w_ready_i,
    output logic [AXI_DATA_WIDTH-1:0]     axi_w_data_o,
    output logic [AXI_DATA_WIDTH/8-1:0]   axi_w_strb_o,
    output logic                          axi_b_ready_o,
    input  logic                          axi_b_valid_i,
    input  logic [1:0]                    axi_b_resp_i,
    output logic                          axi_ar_valid_o,
    input  logic                          axi_ar_ready_i,
    output logic [AXI_ADDR_WIDTH-1:0]     axi_ar_addr_o,
    output logic                          axi_r_ready_o,
    input  logic                          axi_r_valid_i,
    input  logic [1:0]                    axi_r_resp_i,
    input  logic [AXI_DATA_WIDTH-1:0]     axi_r_data_i
);

    localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;

    typedef enum logic [2:0] {IDLE, RD_A, RD_D, WR_AWW, WR_B, RESP} state_t;

    state_t state, state_d;
    logic   aw_done, w_done, aw_done_d, w_done_d;
    logic   accept, misalign;
    logic   ar_hs, r_hs, aw_hs, w_hs, b_hs;

    logic                      req_ready_d, rsp_valid_d;
    logic [AXI_DATA_WIDTH-1:0] rsp_rdata_d;
    logic [1:0]                rsp_resp_d;
    logic                      aw_valid_d, w_valid_d, b_ready_d, ar_valid_d, r_ready_d;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr_d, ar_addr_d;
    logic [AXI_DATA_WIDTH-1:0] w_data_d;
    logic [STRB_W-1:0]         w_strb_d;

    assign accept = req_valid & req_ready;
    assign ar_hs  = axi_ar_valid_o & axi_ar_ready_i;
    assign r_hs   = axi_r_valid_i & axi_r_ready_o;
    assign aw_hs  = axi_aw_valid_o & axi_aw_ready_i;
    assign w_hs   = axi_w_valid_o & axi_w_ready_i;
    assign b_hs   = axi_b_valid_i & axi_b_ready_o;

`ifdef YSYX_22050019_LSU_MISALIGN_CHECK_EN
    // Address must be a multiple of the access size.
    always_comb begin
        misalign = 1'b0;
        case (req_size)
            2'd0:    misalign = 1'b0;
            2'd1:    misalign = req_addr[0];
            2'd2:    misalign = |req_addr[1:0];
            default: misalign = |req_addr[2:0];
        endcase
    end
`else
    logic unused_req_size;
    assign unused_req_size = ^req_size;
    assign misalign        = 1'b0;
`endif

    // State register and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            aw_done        <= 1'b0;
            w_done         <= 1'b0;
            req_ready      <= 1'b1;
            rsp_valid      <= 1'b0;
            rsp_rdata      <= '0;
            rsp_resp       <= 2'b00;
            axi_aw_valid_o <= 1'b0;
            axi_aw_addr_o  <= '0;
            axi_w_valid_o  <= 1'b0;
            axi_w_data_o   <= '0;
            axi_w_strb_o   <= '0;
            axi_b_ready_o  <= 1'b0;
            axi_ar_valid_o <= 1'b0;
            axi_ar_addr_o  <= '0;
            axi_r_ready_o  <= 1'b0;
        end else begin
            state          <= state_d;
            aw_done        <= aw_done_d;
            w_done         <= w_done_d;
            req_ready      <= req_ready_d;
            rsp_valid      <= rsp_valid_d;
            rsp_rdata      <= rsp_rdata_d;
            rsp_resp       <= rsp_resp_d;
            axi_aw_valid_o <= aw_valid_d;
            axi_aw_addr_o  <= aw_addr_d;
            axi_w_valid_o  <= w_valid_d;
            axi_w_data_o   <= w_data_d;
            axi_w_strb_o   <= w_strb_d;
            axi_b_ready_o  <= b_ready_d;
            axi_ar_valid_o <= ar_valid_d;
            axi_ar_addr_o  <= ar_addr_d;
            axi_r_ready_o  <= r_ready_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (misalign)    state_d = RESP;
                    else if (req_we) state_d = WR_AWW;
                    else             state_d = RD_A;
                end
            end
            RD_A:   if (ar_hs) state_d = RD_D;
            RD_D:   if (r_hs)  state_d = RESP;
            WR_AWW: if ((aw_done | aw_hs) & (w_done | w_hs)) state_d = WR_B;
            WR_B:   if (b_hs)  state_d = RESP;
            RESP:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs; payloads hold unless updated.
    always_comb begin
        req_ready_d = (state_d == IDLE);
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata;
        rsp_resp_d  = rsp_resp;
        aw_valid_d  = axi_aw_valid_o;
        aw_addr_d   = axi_aw_addr_o;
        w_valid_d   = axi_w_valid_o;
        w_data_d    = axi_w_data_o;
        w_strb_d    = axi_w_strb_o;
        b_ready_d   = axi_b_ready_o;
        ar_valid_d  = axi_ar_valid_o;
        ar_addr_d   = axi_ar_addr_o;
        r_ready_d   = axi_r_ready_o;
        aw_done_d   = aw_done;
        w_done_d    = w_done;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (misalign) begin
                        rsp_valid_d = 1'b1;
                        rsp_resp_d  = 2'b10;
                        rsp_rdata_d = '0;
                    end else if (req_we) begin
                        aw_valid_d = 1'b1;
                        w_valid_d  = 1'b1;
                        aw_addr_d  = req_addr;
                        w_data_d   = req_wdata;
                        w_strb_d   = req_wstrb;
                        aw_done_d  = 1'b0;
                        w_done_d   = 1'b0;
                    end else begin
                        ar_valid_d = 1'b1;
                        ar_addr_d  = req_addr;
                    end
                end
            end
            RD_A: begin
                if (ar_hs) begin
                    ar_valid_d = 1'b0;
                    r_ready_d  = 1'b1;
                end
            end
            RD_D: begin
                if (r_hs) begin
                    r_ready_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = axi_r_data_i;
                    rsp_resp_d  = axi_r_resp_i;
                end
            end
            WR_AWW: begin
                // Each channel drops on its own handshake and is never re-raised.
                if (aw_hs) begin
                    aw_valid_d = 1'b0;
                    aw_done_d  = 1'b1;
                end
                if (w_hs) begin
                    w_valid_d = 1'b0;
                    w_done_d  = 1'b1;
                end
                if ((aw_done | aw_hs) & (w_done | w_hs)) begin
                    b_ready_d = 1'b1;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            WR_B: begin
                if (b_hs) begin
                    b_ready_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_resp_d  = axi_b_resp_i;
                    rsp_rdata_d = '0;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ysyx_22050019_axi_lsu_master.sv
// Directed bench for ysyx_22050019_axi_lsu_master; the bench plays the AXI responder cycle by cycle.
module tb_ysyx_22050019_axi_lsu_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [63:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic [7:0]  req_wstrb;
    logic        rsp_valid;
    logic [63:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        aw_valid, aw_ready, w_valid, w_ready, b_ready, b_valid;
    logic        ar_valid, ar_ready, r_ready, r_valid;
    logic [63:0] aw_addr, w_data, ar_addr, r_data;
    logic [7:0]  w_strb;
    logic [1:0]  b_resp, r_resp;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ysyx_22050019_axi_lsu_master dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .axi_aw_valid_o(aw_valid), .axi_aw_ready_i(aw_ready), .axi_aw_addr_o(aw_addr),
        .axi_w_valid_o(w_valid), .axi_w_ready_i(w_ready), .axi_w_data_o(w_data), .axi_w_strb_o(w_strb),
        .axi_b_ready_o(b_ready), .axi_b_valid_i(b_valid), .axi_b_resp_i(b_resp),
        .axi_ar_valid_o(ar_valid), .axi_ar_ready_i(ar_ready), .axi_ar_addr_o(ar_addr),
        .axi_r_ready_o(r_ready), .axi_r_valid_i(r_valid), .axi_r_resp_i(r_resp), .axi_r_data_i(r_data)
    );

    task automatic cyc();
        @(negedge clk);
    endtask

    // Present a request for one cycle; the caller's next cyc() lands after acceptance.
    task automatic issue(input logic we, input logic [63:0] addr, input logic [1:0] size,
                         input logic [63:0] wdata, input logic [7:0] wstrb);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
        req_wdata = wdata; req_wstrb = wstrb;
        cyc();
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) cyc();
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_req_ready got %0b exp 1", req_ready); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_rsp_valid got %0b exp 0", rsp_valid); end
        n_cmp++; if ({aw_valid, w_valid, b_ready, ar_valid, r_ready} !== 5'b0) begin n_bad++;
            $display("FAIL rst_axi_handshakes got %05b exp 00000", {aw_valid, w_valid, b_ready, ar_valid, r_ready}); end
        n_cmp++; if ({aw_addr, ar_addr, w_data, w_strb} !== '0) begin n_bad++;
            $display("FAIL rst_axi_payload got aw=%0h ar=%0h w=%0h s=%0h exp 0", aw_addr, ar_addr, w_data, w_strb); end
        n_cmp++; if ({rsp_rdata, rsp_resp} !== '0) begin n_bad++;
            $display("FAIL rst_rsp_data got %0h/%0h exp 0/0", rsp_rdata, rsp_resp); end
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_read();
        issue(1'b0, 64'h8000_0010, 2'd3, 64'h0, 8'h0);
        n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL rd_busy got %0b exp 0", req_ready); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (ar_valid !== 1'b1 || ar_addr !== 64'h8000_0010) begin n_bad++;
                $display("FAIL rd_ar_hold[%0d] got v=%0b a=%0h exp 1/80000010", i, ar_valid, ar_addr); end
            if (i == 2) ar_ready = 1'b1;
            cyc();
        end
        ar_ready = 1'b0;
        n_cmp++; if (ar_valid !== 1'b0 || r_ready !== 1'b1) begin n_bad++;
            $display("FAIL rd_after_ar got ar_v=%0b r_rdy=%0b exp 0/1", ar_valid, r_ready); end
        r_valid = 1'b1; r_data = 64'h1122_3344_5566_7788; r_resp = 2'b00;
        cyc();
        r_valid = 1'b0;
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_rdata !== 64'h1122_3344_5566_7788 || rsp_resp !== 2'b00) begin n_bad++;
            $display("FAIL rd_rsp got v=%0b d=%0h r=%0b exp 1/1122334455667788/00", rsp_valid, rsp_rdata, rsp_resp); end
        n_cmp++; if (r_ready !== 1'b0) begin n_bad++; $display("FAIL rd_r_ready_drop got %0b exp 0", r_ready); end
        cyc();
        n_cmp++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_bad++;
            $display("FAIL rd_done got v=%0b rdy=%0b exp 0/1", rsp_valid, req_ready); end
    endtask

    task automatic test_write_w_delay();
        issue(1'b1, 64'h8000_0020, 2'd2, 64'hDEAD_BEEF, 8'h0F);
        n_cmp++; if ({aw_valid, w_valid} !== 2'b11 || aw_addr !== 64'h8000_0020 || w_data !== 64'hDEAD_BEEF || w_strb !== 8'h0F) begin n_bad++;
            $display("FAIL wr_issue got v=%02b a=%0h d=%0h s=%0h exp 11/80000020/deadbeef/0f", {aw_valid, w_valid}, aw_addr, w_data, w_strb); end
        aw_ready = 1'b1;
        cyc();
        aw_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (aw_valid !== 1'b0 || w_valid !== 1'b1 || w_data !== 64'hDEAD_BEEF || w_strb !== 8'h0F || b_ready !== 1'b0) begin n_bad++;
                $display("FAIL wr_w_hold[%0d] got aw=%0b w=%0b d=%0h s=%0h b=%0b exp 0/1/deadbeef/0f/0", i, aw_valid, w_valid, w_data, w_strb, b_ready); end
            if (i == 2) w_ready = 1'b1;
            cyc();
        end
        w_ready = 1'b0;
        n_cmp++; if (w_valid !== 1'b0 || aw_valid !== 1'b0 || b_ready !== 1'b1) begin n_bad++;
            $display("FAIL wr_b_ready got aw=%0b w=%0b b=%0b exp 0/0/1", aw_valid, w_valid, b_ready); end
        b_valid = 1'b1; b_resp = 2'b00;
        cyc();
        b_valid = 1'b0;
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_resp !== 2'b00 || rsp_rdata !== 64'h0 || b_ready !== 1'b0) begin n_bad++;
            $display("FAIL wr_rsp got v=%0b r=%0b d=%0h b=%0b exp 1/00/0/0", rsp_valid, rsp_resp, rsp_rdata, b_ready); end
        cyc();
        n_cmp++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_bad++;
            $display("FAIL wr_done got v=%0b rdy=%0b exp 0/1", rsp_valid, req_ready); end
    endtask

    task automatic test_write_same_cycle();
        issue(1'b1, 64'h8000_0040, 2'd3, 64'h0123_4567_89AB_CDEF, 8'hFF);
        aw_ready = 1'b1; w_ready = 1'b1;
        cyc();
        n_cmp++; if ({aw_valid, w_valid, b_ready} !== 3'b001) begin n_bad++;
            $display("FAIL sc_wr_b got aw/w/b=%03b exp 001", {aw_valid, w_valid, b_ready}); end
        cyc();
        n_cmp++; if ({aw_valid, w_valid} !== 2'b00) begin n_bad++;
            $display("FAIL sc_no_dup got aw/w=%02b exp 00", {aw_valid, w_valid}); end
        aw_ready = 1'b0; w_ready = 1'b0;
        b_valid = 1'b1; b_resp = 2'b00;
        cyc();
        b_valid = 1'b0;
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_resp !== 2'b00) begin n_bad++;
            $display("FAIL sc_rsp got v=%0b r=%0b exp 1/00", rsp_valid, rsp_resp); end
        cyc();
    endtask

    task automatic test_bresp_err();
        issue(1'b1, 64'h8000_0080, 2'd3, 64'h55, 8'h01);
        w_ready = 1'b1;
        cyc();
        w_ready = 1'b0;
        n_cmp++; if ({aw_valid, w_valid, b_ready} !== 3'b100) begin n_bad++;
            $display("FAIL err_w_first got aw/w/b=%03b exp 100", {aw_valid, w_valid, b_ready}); end
        aw_ready = 1'b1;
        cyc();
        aw_ready = 1'b0;
        cyc();
        n_cmp++; if ({aw_valid, w_valid, b_ready} !== 3'b001 || rsp_valid !== 1'b0) begin n_bad++;
            $display("FAIL err_b_wait got aw/w/b=%03b v=%0b exp 001/0", {aw_valid, w_valid, b_ready}, rsp_valid); end
        b_valid = 1'b1; b_resp = 2'b10;
        cyc();
        b_valid = 1'b0;
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_resp !== 2'b10) begin n_bad++;
            $display("FAIL err_rsp got v=%0b r=%02b exp 1/10", rsp_valid, rsp_resp); end
        cyc();
        n_cmp++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || b_ready !== 1'b0) begin n_bad++;
            $display("FAIL err_idle got rdy=%0b v=%0b b=%0b exp 1/0/0", req_ready, rsp_valid, b_ready); end
    endtask

    task automatic test_reset_mid();
        issue(1'b0, 64'h8000_0100, 2'd3, 64'h0, 8'h0);
        ar_ready = 1'b1;
        cyc();
        ar_ready = 1'b0;
        n_cmp++; if (r_ready !== 1'b1) begin n_bad++; $display("FAIL mid_in_rd_d got r_ready=%0b exp 1", r_ready); end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        n_cmp++; if ({aw_valid, w_valid, b_ready, ar_valid, r_ready, rsp_valid} !== 6'b0 || req_ready !== 1'b1) begin n_bad++;
            $display("FAIL mid_reset got hs=%06b rdy=%0b exp 000000/1", {aw_valid, w_valid, b_ready, ar_valid, r_ready, rsp_valid}, req_ready); end
        cyc();
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL mid_no_rsp got %0b exp 0", rsp_valid); end
        issue(1'b0, 64'h8000_0018, 2'd3, 64'h0, 8'h0);
        n_cmp++; if (ar_valid !== 1'b1 || ar_addr !== 64'h8000_0018) begin n_bad++;
            $display("FAIL mid_reload_ar got v=%0b a=%0h exp 1/80000018", ar_valid, ar_addr); end
        ar_ready = 1'b1;
        cyc();
        ar_ready = 1'b0;
        r_valid = 1'b1; r_data = 64'hCAFE_F00D_1234_5678; r_resp = 2'b00;
        cyc();
        r_valid = 1'b0;
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_rdata !== 64'hCAFE_F00D_1234_5678 || rsp_resp !== 2'b00) begin n_bad++;
            $display("FAIL mid_reload_rsp got v=%0b d=%0h r=%0b exp 1/cafef00d12345678/00", rsp_valid, rsp_rdata, rsp_resp); end
        cyc();
    endtask

    task automatic test_misalign();
        issue(1'b0, 64'h8000_0002, 2'd2, 64'h0, 8'h0);
`ifdef YSYX_22050019_LSU_MISALIGN_CHECK_EN
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_resp !== 2'b10 || rsp_rdata !== 64'h0 || ar_valid !== 1'b0) begin n_bad++;
            $display("FAIL mis_rsp got v=%0b r=%02b d=%0h ar=%0b exp 1/10/0/0", rsp_valid, rsp_resp, rsp_rdata, ar_valid); end
        cyc();
        n_cmp++; if (req_ready !== 1'b1 || ar_valid !== 1'b0 || rsp_valid !== 1'b0) begin n_bad++;
            $display("FAIL mis_idle got rdy=%0b ar=%0b v=%0b exp 1/0/0", req_ready, ar_valid, rsp_valid); end
`else
        n_cmp++; if (ar_valid !== 1'b1 || ar_addr !== 64'h8000_0002 || rsp_valid !== 1'b0) begin n_bad++;
            $display("FAIL mis_to_bus got ar=%0b a=%0h v=%0b exp 1/80000002/0", ar_valid, ar_addr, rsp_valid); end
        ar_ready = 1'b1;
        cyc();
        ar_ready = 1'b0;
        r_valid = 1'b1; r_data = 64'hA5A5; r_resp = 2'b00;
        cyc();
        r_valid = 1'b0;
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_rdata !== 64'hA5A5) begin n_bad++;
            $display("FAIL mis_rsp got v=%0b d=%0h exp 1/a5a5", rsp_valid, rsp_rdata); end
        cyc();
`endif
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_size = '0;
        req_wdata = '0; req_wstrb = '0;
        aw_ready = 1'b0; w_ready = 1'b0; b_valid = 1'b0; b_resp = '0;
        ar_ready = 1'b0; r_valid = 1'b0; r_resp = '0; r_data = '0;
        test_reset();
        test_read();
        test_write_w_delay();
        test_write_same_cycle();
        test_bresp_err();
        test_reset_mid();
        test_misalign();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ysyx_22050019_axi_lsu_master.md
# ysyx_22050019_axi_lsu_master

AXI-lite initiator on the LSU side of the memory path. It turns single LSU load/store requests into one AXI read (AR→R) or one AXI write (AW+W→B) transaction, with 64-bit address and data. It returns the read data and response code to the LSU. It sits between the LSU/MEM stage and the AXI arbiter and SRAM responder.

## Interface
- AXI_DATA_WIDTH, 64, data width; strobe width is AXI_DATA_WIDTH/8
- AXI_ADDR_WIDTH, 64, address width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  LSU request valid
- req_ready  out  1  request accepted when req_valid & req_ready
- req_we  in  1  1 = store, 0 = load
- req_addr  in  AXI_ADDR_WIDTH  byte address
- req_size  in  2  log2 access bytes (0=1B … 3=8B)
- req_wdata  in  AXI_DATA_WIDTH  store data, already lane-aligned
- req_wstrb  in  AXI_DATA_WIDTH/8  store byte mask
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  AXI_DATA_WIDTH  raw 64-bit read beat; 0 for stores
- rsp_resp  out  2  AXI response code (00 OKAY, 10 SLVERR)
- axi_aw_valid_o  out  1
- axi_aw_ready_i  in  1
- axi_aw_addr_o  out  AXI_ADDR_WIDTH
- axi_w_valid_o  out  1
- axi_w_ready_i  in  1
- axi_w_data_o  out  AXI_DATA_WIDTH
- axi_w_strb_o  out  AXI_DATA_WIDTH/8
- axi_b_ready_o  out  1
- axi_b_valid_i  in  1
- axi_b_resp_i  in  2
- axi_ar_valid_o  out  1
- axi_ar_ready_i  in  1
- axi_ar_addr_o  out  AXI_ADDR_WIDTH
- axi_r_ready_o  out  1
- axi_r_valid_i  in  1
- axi_r_resp_i  in  2
- axi_r_data_i  in  AXI_DATA_WIDTH

## Operation
- FSM states: IDLE, RD_A, RD_D, WR_AWW, WR_B, RESP.
- req_ready = (state==IDLE). All other outputs are registered.
- IDLE, on acceptance:
  - Latch addr/wdata/wstrb.
  - If req_we=0: go to RD_A with ar_valid=1.
  - If req_we=1: go to WR_AWW with aw_valid=1 and w_valid=1.
- RD_A:
  - Hold ar_valid and ar_addr stable until axi_ar_ready_i.
  - On handshake: ar_valid←0, r_ready←1, go to RD_D.
- RD_D:
  - On axi_r_valid_i & r_ready: capture data/resp, r_ready←0, go to RESP.
- WR_AWW:
  - aw_valid and w_valid drop independently on their own handshakes, tracked by aw_done/w_done flags.
  - Once both are done (handshakes may land in the same cycle or in either order): b_ready←1, go to WR_B.
  - Never re-assert a channel that has already handshaken.
- WR_B:
  - On axi_b_valid_i & b_ready: capture b_resp, b_ready←0, go to RESP.
- RESP:
  - rsp_valid=1 for exactly one cycle, then IDLE.
  - rsp_rdata holds the captured beat (reads) or 0 (writes).
  - rsp_resp is passed through unmodified; non-OKAY responses are not retried.
- Only one transaction is outstanding at a time; reads and writes never overlap.
- Reset values:
  - req_ready=1 (IDLE).
  - rsp_valid=0, rsp_rdata=0, rsp_resp=0.
  - All AXI valid/ready outputs 0; all AXI address/data/strb outputs 0.
- Reset mid-transaction:
  - Next edge: state→IDLE, all valids/readies deasserted, no rsp_valid.
  - The transaction is abandoned; the responder shares rst.

## Timing
- Acceptance at cycle 0 → AR or AW/W valid visible at cycle 1.
- Read with zero-wait responder (ar_ready high, r_valid at cycle N): rsp_valid at cycle N+1.
- Write: b_ready asserted the cycle after the last of the AW/W handshakes; rsp_valid the cycle after the B handshake.
- Minimum turnaround: a new request is accepted the cycle after rsp_valid.
- Stalls of any length on ar_ready/aw_ready/w_ready/r_valid/b_valid are tolerated, with payload held stable.

## Configuration
- YSYX_22050019_LSU_MISALIGN_CHECK_EN:
  - Defined: a request with req_addr not aligned to 2^req_size issues no AXI traffic and goes IDLE→RESP directly, giving rsp_valid at cycle 1 with rsp_resp=2'b10 and rsp_rdata=0.
  - Undefined: req_size is ignored and every request goes to the bus.

## Test plan
- Load addr 0x8000_0010, responder returns 0x1122334455667788 OKAY after 2 wait cycles → one rsp_valid pulse, rsp_rdata=0x1122334455667788, rsp_resp=00; ar_valid high until handshake.
- Store addr 0x8000_0020, wdata 0xDEADBEEF, wstrb 0x0F, w_ready delayed 3 cycles after aw_ready → aw drops after its handshake, w held stable, one B handshake, rsp_valid with rsp_resp=00, rsp_rdata=0.
- Store with aw_ready and w_ready both high in the same cycle → WR_B entered next cycle; no duplicate AW/W beats.
- Responder returns b_resp=10 → rsp_resp=10, then FSM back in IDLE with req_ready=1.
- rst asserted during RD_D → next cycle all AXI valids/readies 0, req_ready=1, no rsp_valid; a subsequent load completes normally.
- With the macro defined, load size=2 at addr 0x8000_0002 → rsp_valid at cycle 1, rsp_resp=10, ar_valid never asserted.
